// File: rtl/sw_bounce_gen_if.sv
// Request/status bundle between a bounce-generator user (master) and sw_bounce_gen (slave).
// sw is the raw, bouncing switch line; n_bounce reports its edge count for the last transition.
interface sw_bounce_gen_if;
  logic       req;
  logic       level;
  logic       rnd_en;
  logic       sw;
  logic       busy;
  logic       done;
  logic [4:0] n_bounce;

  modport master (
    output req,
    output level,
    output rnd_en,
    input  sw,
    input  busy,
    input  done,
    input  n_bounce
  );

  modport slave (
    input  req,
    input  level,
    input  rnd_en,
    output sw,
    output busy,
    output done,
    output n_bounce
  );
endinterface

// File: rtl/sw_bounce_gen.sv
// Mechanical-switch emulator: drives a target level with k glitch pairs of length G each,
// then holds the level for a settle window and pulses done. Gaps fixed or LFSR-drawn.
module sw_bounce_gen #(
  parameter int unsigned BOUNCE_PAIRS = 3,
  parameter int unsigned MIN_GAP      = 16,
  parameter int unsigned SETTLE_CYC   = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic            clk50m,
  input logic            rst_n,
  sw_bounce_gen_if.slave bus
);

  localparam int unsigned SegW = $clog2(MIN_GAP + 16);
  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);

  localparam logic [3:0]      PairsMax   = 4'(BOUNCE_PAIRS);
  localparam logic [SegW-1:0] GapFixM1   = SegW'(MIN_GAP - 1);
  localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYC - 1);

  if (BOUNCE_PAIRS > 15) begin : g_bad_pairs
    $error("BOUNCE_PAIRS must be in 0..15");
  end
  if (MIN_GAP < 1) begin : g_bad_gap
    $error("MIN_GAP must be >= 1");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("SETTLE_CYC must be >= 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    StIdle,
    StHiSeg,
    StLoSeg,
    StSettle
  } state_e;

  state_e          state_q;
  logic [15:0]     lfsr_q;
  logic [SegW-1:0] seg_cnt_q;
  logic [SetW-1:0] set_cnt_q;
  logic [3:0]      pairs_q;
  logic            level_q;
  logic            rnd_q;
  logic            same_pend_q;
  logic            sw_q;
  logic            busy_q;
  logic            done_q;
  logic [4:0]      n_bounce_q;

  logic            lfsr_fb;
  logic [3:0]      nib;
  logic [3:0]      k_req;
  logic [SegW-1:0] gap_req_m1;
  logic [SegW-1:0] gap_lat_m1;

  // Fibonacci taps 16,14,13,11
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign nib     = lfsr_q[3:0];

  always_comb begin
    k_req = PairsMax;
    if (bus.rnd_en && (nib < PairsMax)) begin
      k_req = nib;
    end
  end

  // Counters are loaded with G-1 so a segment spans exactly G edges.
  assign gap_req_m1 = bus.rnd_en ? (GapFixM1 + SegW'(nib)) : GapFixM1;
  assign gap_lat_m1 = rnd_q      ? (GapFixM1 + SegW'(nib)) : GapFixM1;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEED;
      seg_cnt_q   <= '0;
      set_cnt_q   <= '0;
      pairs_q     <= '0;
      level_q     <= 1'b0;
      rnd_q       <= 1'b0;
      same_pend_q <= 1'b0;
      sw_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      n_bounce_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (same_pend_q) begin
            same_pend_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (bus.req && !done_q) begin
            if (bus.level != sw_q) begin
              sw_q       <= bus.level;
              busy_q     <= 1'b1;
              level_q    <= bus.level;
              rnd_q      <= bus.rnd_en;
              pairs_q    <= k_req;
              n_bounce_q <= {k_req, 1'b1};
              if (k_req != 4'd0) begin
                state_q   <= StHiSeg;
                seg_cnt_q <= gap_req_m1;
              end else begin
                state_q   <= StSettle;
                set_cnt_q <= SettleLoad;
              end
            end else begin
              // Already at the requested level: no edge, just acknowledge.
              n_bounce_q  <= '0;
              same_pend_q <= 1'b1;
            end
          end
        end

        StHiSeg: begin
          if (seg_cnt_q == '0) begin
            sw_q      <= ~level_q;
            seg_cnt_q <= gap_lat_m1;
            state_q   <= StLoSeg;
          end else begin
            seg_cnt_q <= seg_cnt_q - 1'b1;
          end
        end

        StLoSeg: begin
          if (seg_cnt_q == '0) begin
            sw_q    <= level_q;
            pairs_q <= pairs_q - 1'b1;
            if (pairs_q == 4'd1) begin
              state_q   <= StSettle;
              set_cnt_q <= SettleLoad;
            end else begin
              state_q   <= StHiSeg;
              seg_cnt_q <= gap_lat_m1;
            end
          end else begin
            seg_cnt_q <= seg_cnt_q - 1'b1;
          end
        end

        StSettle: begin
          if (set_cnt_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            set_cnt_q <= set_cnt_q - 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sw       = sw_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.n_bounce = n_bounce_q;

endmodule
